piso_feeder: RTL and testbench

Parallel-in/serial-out feeder for the loadable D flip-flop stage. It accepts a WIDTH-bit word through a valid/ready handshake, then presents the word one bit per clock on D, asserting LD for every valid bit. The downstream flip-flop captures each bit on the following CK edge. It is the stage directly upstream of the flip-flop: its D/LD outputs connect straight to that stage's D/LD inputs.

---
 rtl/piso_feeder_pkg.sv | 17 +
 rtl/piso_feeder_bit_cnt.sv | 34 +++
 rtl/piso_feeder.sv | 145 ++++++++++++++
 tb/tb_piso_feeder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_feeder_pkg.sv
// piso_feeder shared definitions: FSM state encoding and counter sizing.
// Optional parity frame bit is enabled with `define PISO_FEEDER_PARITY_EN.
package piso_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit counter holds WIDTH+1 distinct values.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_feeder_bit_cnt.sv
// bit_cnt: loadable bit-index up-counter with clear and terminal-count flag.
// Saturates at WIDTH-1 so it never wraps inside a frame.
module bit_cnt
    import piso_feeder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    input  logic          inc,
    output logic          tc
);

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_feeder.sv
// piso_feeder: valid/ready word in, registered D/LD bit stream out.
// Define PISO_FEEDER_PARITY_EN to append an even-parity bit to each frame.
module piso_feeder
    import piso_feeder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CK,
    input  logic             RB,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DVALID,
    output logic             DREADY,
    output logic             D,
    output logic             LD,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] sreg_rot;
    logic             d_d;
    logic             ld_d;
    logic             done_d;
    logic             cnt_clr;
    logic             cnt_ld;
    logic             cnt_inc;
    logic             cnt_tc;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Rotate rather than shift so the next bit always sits at the head.
    assign sreg_rot = MSB_FIRST ? {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]}
                                : {sreg_q[0], sreg_q[WIDTH-1:1]};

    assign DREADY = (state_q == ST_IDLE);
    assign BUSY   = (state_q != ST_IDLE);

    bit_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_cnt (
        .clk    (CK),
        .rst_n  (RB),
        .clr    (cnt_clr),
        .ld     (cnt_ld),
        .ld_val ('0),
        .inc    (cnt_inc),
        .tc     (cnt_tc)
    );

`ifdef PISO_FEEDER_PARITY_EN
    logic par_q;

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            par_q <= 1'b0;
        end else if (state_q == ST_IDLE && DVALID) begin
            par_q <= ^DIN;
        end
    end
`endif

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        d_d     = 1'b0;
        ld_d    = 1'b0;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_ld  = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (DVALID) begin
                    state_d = ST_SHIFT;
                    sreg_d  = DIN;
                    d_d     = head(DIN);
                    ld_d    = 1'b1;
                    cnt_ld  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_tc) begin
`ifdef PISO_FEEDER_PARITY_EN
                    state_d = ST_PAR;
                    d_d     = par_q;
                    ld_d    = 1'b1;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    sreg_d  = sreg_rot;
                    d_d     = head(sreg_rot);
                    ld_d    = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
`ifdef PISO_FEEDER_PARITY_EN
            ST_PAR: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            sreg_q <= '0;
            D      <= 1'b0;
            LD     <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            D      <= d_d;
            LD     <= ld_d;
            DONE   <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_feeder.sv
// Self-checking bench for piso_feeder: MSB-first and LSB-first instances.
// Frame-position reference model plus table vectors and corner sequences.
module tb_piso_feeder;

    localparam int W = 8;
`ifdef PISO_FEEDER_PARITY_EN
    localparam int NB = W + 1;
    localparam bit PAR_ON = 1'b1;
`else
    localparam int NB = W;
    localparam bit PAR_ON = 1'b0;
`endif

    logic         CK = 1'b0;
    logic         RB = 1'b0;
    logic [W-1:0] din = '0;
    logic         dvalid = 1'b0;
    logic [1:0]   dready;
    logic [1:0]   d;
    logic [1:0]   ld;
    logic [1:0]   busy;
    logic [1:0]   done;
    logic [1:0]   ff_q;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the current frame, -1 when idle.
    int           pos = -1;
    logic [W-1:0] word = '0;

    piso_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .CK(CK), .RB(RB), .DIN(din), .DVALID(dvalid),
        .DREADY(dready[1]), .D(d[1]), .LD(ld[1]),
        .BUSY(busy[1]), .DONE(done[1])
    );

    piso_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .CK(CK), .RB(RB), .DIN(din), .DVALID(dvalid),
        .DREADY(dready[0]), .D(d[0]), .LD(ld[0]),
        .BUSY(busy[0]), .DONE(done[0])
    );

    always #5 CK = ~CK;

    // Downstream loadable flip-flops.
    always @(posedge CK) begin
        if (ld[1]) ff_q[1] <= d[1];
        if (ld[0]) ff_q[0] <= d[0];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bitv(input int msb, input int p);
        if (p >= W) return ^word;
        return msb != 0 ? word[W-1-p] : word[p];
    endfunction

    function automatic logic [4:0] exp_out(input int msb);
        logic l;
        logic b;
        l = (pos >= 0) && (pos < NB);
        b = l ? bitv(msb, pos) : 1'b0;
        return {pos < 0, pos >= 0, pos == NB, l, b};
    endfunction

    task automatic cmp_all();
        check("msb_outs", {27'd0, dready[1], busy[1], done[1], ld[1], d[1]},
              {27'd0, exp_out(1)});
        check("lsb_outs", {27'd0, dready[0], busy[0], done[0], ld[0], d[0]},
              {27'd0, exp_out(0)});
    endtask

    task automatic step();
        @(posedge CK);
        if (!RB) begin
            pos = -1;
        end else if (pos < 0) begin
            if (dvalid) begin
                word = din;
                pos  = 0;
            end
        end else begin
            pos++;
            if (pos > NB) pos = -1;
        end
        #1;
        cmp_all();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (dready != 2'b11 && n < 50) begin
            step();
            n++;
        end
        check("idle_timeout", {30'd0, dready}, 32'd3);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
        logic       par;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [7:0] cm, cl;
        logic       pm, pl;
        int         ldn, done_at, nrdy, acc_n;
        logic       prev_rdy;

        vt[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
        vt[1] = '{8'h01, 8'h01, 8'h80, 1'b1};
        vt[2] = '{8'h07, 8'h07, 8'hE0, 1'b1};
        vt[3] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};
        vt[4] = '{8'h12, 8'h12, 8'h48, 1'b0};

        // Reset held with DVALID asserted: nothing may be accepted.
        RB     = 1'b0;
        dvalid = 1'b1;
        din    = 8'hA5;
        #1;
        cmp_all();
        step();
        step();
        RB     = 1'b1;
        dvalid = 1'b0;
        step();

        foreach (vt[i]) begin
            wait_idle();
            dvalid = 1'b1;
            din    = vt[i].din;
            step();
            dvalid  = 1'b0;
            din     = W'($urandom);
            cm      = '0;
            cl      = '0;
            pm      = 1'b0;
            pl      = 1'b0;
            ldn     = 0;
            done_at = 0;
            nrdy    = 0;
            for (int k = 0; k <= NB + 2; k++) begin
                if (ld[1]) begin
                    ldn++;
                    if (k < W) begin
                        cm = {cm[6:0], d[1]};
                        cl = {cl[6:0], d[0]};
                    end else begin
                        pm = d[1];
                        pl = d[0];
                    end
                end
                if (done[1]) done_at = k + 1;
                if (!dready[1]) nrdy++;
                din = W'($urandom);
                step();
            end
            check("vec_msb_bits", {24'd0, cm}, {24'd0, vt[i].exp_msb});
            check("vec_lsb_bits", {24'd0, cl}, {24'd0, vt[i].exp_lsb});
            check("vec_ld_count", ldn, NB);
            check("vec_done_cycle", done_at, NB + 1);
            check("vec_busy_cycles", nrdy, NB + 1);
            if (PAR_ON) begin
                check("vec_par_msb", {31'd0, pm}, {31'd0, vt[i].par});
                check("vec_par_lsb", {31'd0, pl}, {31'd0, vt[i].par});
            end
            check("ff_q_msb", {31'd0, ff_q[1]},
                  {31'd0, PAR_ON ? vt[i].par : vt[i].exp_msb[0]});
            check("ff_q_lsb", {31'd0, ff_q[0]},
                  {31'd0, PAR_ON ? vt[i].par : vt[i].exp_lsb[0]});
        end

        // DVALID held high with changing DIN: one accept per frame period.
        wait_idle();
        dvalid   = 1'b1;
        acc_n    = 0;
        prev_rdy = 1'b1;
        for (int c = 0; c < 3 * (NB + 2); c++) begin
            din = W'($urandom);
            step();
            if (prev_rdy && !dready[1]) begin
                check("accept_edge", c, acc_n * (NB + 2));
                acc_n++;
            end
            prev_rdy = dready[1];
        end
        dvalid = 1'b0;
        check("accept_count", acc_n, 3);

        // Reset between E0+3 and E0+4 discards the frame.
        wait_idle();
        dvalid = 1'b1;
        din    = W'($urandom);
        step();
        dvalid = 1'b0;
        step();
        step();
        step();
        #2;
        RB  = 1'b0;
        pos = -1;
        #1;
        cmp_all();
        check("rst_ld_drop", {30'd0, ld}, 32'd0);
        step();
        step();
        RB     = 1'b1;
        dvalid = 1'b1;
        din    = 8'hFF;
        step();
        dvalid = 1'b0;
        cm     = '0;
        cl     = '0;
        for (int k = 0; k < W; k++) begin
            cm = {cm[6:0], d[1] & ld[1]};
            cl = {cl[6:0], d[0] & ld[0]};
            step();
        end
        check("post_rst_msb", {24'd0, cm}, 32'hFF);
        check("post_rst_lsb", {24'd0, cl}, 32'hFF);

        // Random traffic with occasional reset pulses.
        for (int c = 0; c < 400; c++) begin
            dvalid = ($urandom_range(0, 3) != 0);
            din    = W'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                RB = 1'b0;
                step();
                RB = 1'b1;
            end
            step();
        end
        dvalid = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
